alu_serial_ctrl: RTL and testbench

Bit-serial sequencer that drives one external 1-bit ALU slice, one bit per clock. It accepts a WIDTH-bit operation through a start/busy/done handshake and walks bits 0..WIDTH-1 through the slice. Along the way it chains the carry, collects result bits, and resolves SLT from the MSB pass. It is the initiator end of the slice interface: it drives a/b/cin/less/op and consumes result/cout/set. It lets area-constrained datapaths reuse a single slice instead of a ripple array.

---
 rtl/alu_serial_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// alu_serial_ctrl: bit-serial sequencer for a single external 1-bit ALU slice.
// Accepts a WIDTH-bit operation through start/busy/done and walks the slice
// from bit 0 to bit WIDTH-1. The carry is chained through a register and result
// bits are collected. Flags and the SLT result are resolved on the MSB pass.
// The slice_* drive is registered and precomputed from next-state values, so
// the slice always sees the operand bits for the index being processed.

module alu_serial_ctrl #(
    parameter int WIDTH = 32,
    parameter int IDXW  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic             slice_less,
    output logic [2:0]       slice_op,
    input  logic             slice_result,
    input  logic             slice_cout,
    input  logic             slice_set
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);
    localparam logic [2:0]      OP_ADD   = 3'b010;
    localparam logic [2:0]      OP_SUB   = 3'b110;
    localparam logic [2:0]      OP_SLT   = 3'b111;

    // Only the adder-based ops report carry and overflow.
    function automatic logic is_arith(input logic [2:0] o);
        return (o == OP_ADD) || (o == OP_SUB) || (o == OP_SLT);
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             slice_a_q, slice_a_d;
    logic             slice_b_q, slice_b_d;
    logic             slice_cin_q, slice_cin_d;
    logic [2:0]       slice_op_q, slice_op_d;

    logic             accept_s;
    logic             ovf_s;
    logic             cout_s;
    logic [WIDTH-1:0] full_s;

    // Next-state, datapath collection and registered-output computation.
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        idx_d      = idx_q;
        carry_d    = carry_q;
        acc_d      = acc_q;
        result_d   = result_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;
        ovf_s      = 1'b0;
        cout_s     = 1'b0;
        full_s     = acc_q;
        // start is only honoured while not busy; there is no queueing.
        accept_s   = start && (state_q != ST_RUN);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    idx_d   = '0;
                    carry_d = op[2];
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_d[idx_q] = slice_result;
                carry_d      = slice_cout;
                idx_d        = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    full_s[WIDTH-1] = slice_result;
                    if (is_arith(op_q)) begin
                        cout_s = slice_cout;
                        // carry into the MSB is still held in carry_q here
                        ovf_s  = carry_q ^ slice_cout;
                    end else begin
                        cout_s = 1'b0;
                        ovf_s  = 1'b0;
                    end
                    if (op_q == OP_SLT) begin
                        full_s    = '0;
                        full_s[0] = slice_set ^ ovf_s;
                    end else begin
                        full_s = full_s;
                    end
                    result_d   = full_s;
                    cout_d     = cout_s;
                    overflow_d = ovf_s;
                    zero_d     = (full_s == '0);
                    idx_d      = '0;
                    state_d    = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);

        if (state_d == ST_RUN) begin
            slice_a_d   = a_d[idx_d];
            slice_b_d   = b_d[idx_d];
            slice_cin_d = carry_d;
            slice_op_d  = op_d;
        end else begin
            slice_a_d   = 1'b0;
            slice_b_d   = 1'b0;
            slice_cin_d = 1'b0;
            slice_op_d  = 3'b000;
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= 3'b000;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            acc_q       <= '0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            slice_a_q   <= 1'b0;
            slice_b_q   <= 1'b0;
            slice_cin_q <= 1'b0;
            slice_op_q  <= 3'b000;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            cout_q      <= cout_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            slice_a_q   <= slice_a_d;
            slice_b_q   <= slice_b_d;
            slice_cin_q <= slice_cin_d;
            slice_op_q  <= slice_op_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign cout       = cout_q;
    assign overflow   = overflow_q;
    assign zero       = zero_q;
    assign slice_a    = slice_a_q;
    assign slice_b    = slice_b_q;
    assign slice_cin  = slice_cin_q;
    assign slice_less = 1'b0;
    assign slice_op   = slice_op_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed self-checking bench for alu_serial_ctrl (WIDTH=8) with a
// behavioural 1-bit ALU slice attached to the slice interface.

module tb_alu_serial_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy, done, cout, overflow, zero;
    logic [W-1:0] result;
    logic         slice_a, slice_b, slice_cin, slice_less;
    logic [2:0]   slice_op;
    logic         slice_result, slice_cout, slice_set;

    int checks   = 0;
    int failures = 0;

    alu_serial_ctrl #(.WIDTH(W), .IDXW(3)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout(cout),
        .overflow(overflow), .zero(zero),
        .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
        .slice_less(slice_less), .slice_op(slice_op),
        .slice_result(slice_result), .slice_cout(slice_cout), .slice_set(slice_set)
    );

    always #5 clk = ~clk;

    // Behavioural 1-bit ALU slice: bnegate=op[2], select=op[1:0].
    logic bb_s, sum_s;
    always_comb begin
        bb_s       = slice_b ^ slice_op[2];
        sum_s      = slice_a ^ bb_s ^ slice_cin;
        slice_cout = (slice_a & bb_s) | (slice_a & slice_cin) | (bb_s & slice_cin);
        slice_set  = sum_s;
        case (slice_op[1:0])
            2'b00:   slice_result = slice_a & bb_s;
            2'b01:   slice_result = slice_a | bb_s;
            2'b10:   slice_result = sum_s;
            default: slice_result = slice_less;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete operation: start pulse, latency check, result and flags.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] er,
                          input logic ec, input logic ev, input logic ez);
        int n;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_cin0"}, 64'(slice_cin), 64'(o[2]));
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(W));
        chk({tag, "_result"}, 64'(result), 64'(er));
        chk({tag, "_cout"}, 64'(cout), 64'(ec));
        chk({tag, "_ovf"}, 64'(overflow), 64'(ev));
        chk({tag, "_zero"}, 64'(zero), 64'(ez));
        chk({tag, "_idle_slice"}, 64'({slice_a, slice_b, slice_cin, slice_op}), 64'd0);
    endtask

    int n_done;

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_zero", 64'(zero), 64'd1);
        chk("rst_flags", 64'({cout, overflow}), 64'd0);
        @(negedge clk); reset = 1'b0;

        run_op("add_5_3",   3'b010, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0);
        run_op("sub_3_5",   3'b110, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_op("add_7f_1",  3'b010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("add_ff_1",  3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("slt_80_1",  3'b111, 8'h80, 8'h01, 8'h01, 1'b1, 1'b1, 1'b0);
        run_op("slt_5_3",   3'b111, 8'h05, 8'h03, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("slt_ff_1",  3'b111, 8'hFF, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0);
        run_op("and",       3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
        run_op("or",        3'b001, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0);

        // Second start while busy is ignored: one done, first op's result.
        @(negedge clk);
        op = 3'b010; a = 8'h11; b = 8'h22; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); op = 3'b000; a = 8'h0F; b = 8'h0F; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        chk("ign_done_count", 64'(n_done), 64'd1);
        chk("ign_result", 64'(result), 64'h33);

        // Start held through DONE: second op begins with no IDLE cycle.
        @(negedge clk);
        op = 3'b010; a = 8'h05; b = 8'h03; start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < W; i++) begin
            @(posedge clk); #1;
        end
        chk("b2b_done1", 64'(done), 64'd1);
        chk("b2b_res1", 64'(result), 64'h08);
        @(negedge clk); op = 3'b110; a = 8'h40; b = 8'h01;
        @(posedge clk); #1;
        chk("b2b_busy", 64'(busy), 64'd1);
        chk("b2b_no_done", 64'(done), 64'd0);
        chk("b2b_res_held", 64'(result), 64'h08);
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(posedge clk); #1;
        end
        chk("b2b_done2", 64'(done), 64'd1);
        chk("b2b_res2", 64'(result), 64'h3F);

        // Asynchronous reset mid-RUN at bit index 4.
        @(negedge clk);
        op = 3'b001; a = 8'hAA; b = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        chk("rst_mid_busy_before", 64'(busy), 64'd1);
        #2; reset = 1'b1; #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        chk("rst_mid_result", 64'(result), 64'd0);
        chk("rst_mid_zero", 64'(zero), 64'd1);
        chk("rst_mid_slice", 64'({slice_a, slice_b, slice_cin, slice_op}), 64'd0);
        @(negedge clk); reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done || busy) n_done++;
        end
        chk("rst_mid_no_done", 64'(n_done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
